// File: rtl/booth_controller.sv
`default_nettype none
// ============================================================================
//  Module      : booth_controller
//  Description : Sequencing FSM for a radix-2 Booth datapath. It loads the
//                operands, runs add/sub + arithmetic-shift iterations steered
//                by {q0,qm1}, and finishes when the datapath reports eqz.
//                Flags a sticky error if eqz does not arrive within N shifts.
//  Revision    : 1.0  initial release
// ============================================================================
module booth_controller #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic q0,
    input  logic qm1,
    input  logic eqz,
    output logic load,
    output logic do_add,
    output logic do_add_valid,
    output logic do_shift,
    output logic busy,
    output logic done,
    output logic result_valid,
    output logic error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CHECK  = 3'd2,
        S_ADDSUB = 3'd3,
        S_SHIFT  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Shift count at which a missing eqz becomes a protocol error
    localparam logic [CNT_W-1:0] C_SHIFT_LIMIT = CNT_W'(N);
    localparam logic [CNT_W-1:0] C_CNT_ONE     = CNT_W'(1);

    state_t           state_q,        state_d;
    logic [CNT_W-1:0] cnt_q,          cnt_d;
    logic             error_q,        error_d;
    logic             result_valid_q, result_valid_d;
    logic             load_q,         load_d;
    logic             do_add_q,       do_add_d;
    logic             do_add_valid_q, do_add_valid_d;
    logic             do_shift_q,     do_shift_d;
    logic             busy_q,         busy_d;
    logic             done_q,         done_d;
    logic             add_sel_d;

    // Next-state, shift counter, sticky error and result_valid bookkeeping
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        error_d        = error_q;
        result_valid_d = result_valid_q;
        add_sel_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_LOAD;
                    cnt_d          = '0;
                    error_d        = 1'b0;
                    result_valid_d = 1'b0;
                end
            end
            S_LOAD: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (eqz) begin
                    state_d = S_DONE;
                end else if (cnt_q >= C_SHIFT_LIMIT) begin
                    // Datapath never reported completion: overrun
                    state_d = S_DONE;
                    error_d = 1'b1;
                end else if ({q0, qm1} == 2'b01) begin
                    state_d   = S_ADDSUB;
                    add_sel_d = 1'b1;
                end else if ({q0, qm1} == 2'b10) begin
                    state_d   = S_ADDSUB;
                    add_sel_d = 1'b0;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_ADDSUB: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                state_d = S_CHECK;
                cnt_d   = cnt_q + C_CNT_ONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition except the start-from-idle path
        if (abort && (state_q != S_IDLE)) begin
            state_d        = S_IDLE;
            cnt_d          = cnt_q;
            error_d        = error_q;
            result_valid_d = 1'b0;
            add_sel_d      = 1'b0;
        end

        if (state_d == S_DONE) begin
            result_valid_d = 1'b1;
        end
    end

    // Strobes are decoded from the next state so they are registered yet Moore
    always_comb begin
        load_d         = (state_d == S_LOAD);
        do_add_valid_d = (state_d == S_ADDSUB);
        do_add_d       = (state_d == S_ADDSUB) && add_sel_d;
        do_shift_d     = (state_d == S_SHIFT);
        done_d         = (state_d == S_DONE);
        busy_d         = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            error_q        <= 1'b0;
            result_valid_q <= 1'b0;
            load_q         <= 1'b0;
            do_add_q       <= 1'b0;
            do_add_valid_q <= 1'b0;
            do_shift_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            error_q        <= error_d;
            result_valid_q <= result_valid_d;
            load_q         <= load_d;
            do_add_q       <= do_add_d;
            do_add_valid_q <= do_add_valid_d;
            do_shift_q     <= do_shift_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign load         = load_q;
    assign do_add       = do_add_q;
    assign do_add_valid = do_add_valid_q;
    assign do_shift     = do_shift_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;

endmodule
`default_nettype wire
